// File: rtl/imu_pkg.sv
// Shared types and constants for the IMU SPI responder.
//   data_t        : parallel sample {pitch, roll, yaw, x, y, z}, 16 bits each, pitch in the MSBs.
//   ADDR_*        : register addresses (7-bit).
//   resp_state_e  : responder frame FSM states.
//   out_byte()    : picks one little-endian output byte (0 = pitch[7:0] ... 11 = z[15:8]).
// Optional build macro: IMU_RESP_AUTOINC_EN (changes the CTRL3_C reset value).
package imu_pkg;

  typedef struct packed {
    logic [15:0] pitch;
    logic [15:0] roll;
    logic [15:0] yaw;
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] z;
  } data_t;

  localparam logic [6:0] ADDR_WHO_AM_I  = 7'h0F;
  localparam logic [6:0] ADDR_CTRL1_XL  = 7'h10;
  localparam logic [6:0] ADDR_CTRL2_G   = 7'h11;
  localparam logic [6:0] ADDR_CTRL3_C   = 7'h12;
  localparam logic [6:0] ADDR_CTRL4_C   = 7'h13;
  localparam logic [6:0] ADDR_CTRL9_XL  = 7'h18;
  localparam logic [6:0] ADDR_STATUS    = 7'h1E;
  localparam logic [6:0] ADDR_OUTX_L_G  = 7'h22;
  localparam logic [6:0] ADDR_OUTZ_H_XL = 7'h2D;

  localparam logic [7:0] CTRL9_XL_RST = 8'hE0;
`ifdef IMU_RESP_AUTOINC_EN
  localparam logic [7:0] CTRL3_C_RST  = 8'h04;
`else
  localparam logic [7:0] CTRL3_C_RST  = 8'h00;
`endif

  typedef enum logic [1:0] {
    StWaitCs,
    StIdle,
    StAddr,
    StData
  } resp_state_e;

  function automatic logic [7:0] out_byte(data_t d, logic [3:0] idx);
    logic [15:0] w;
    case (idx[3:1])
      3'd0:    w = d.pitch;
      3'd1:    w = d.roll;
      3'd2:    w = d.yaw;
      3'd3:    w = d.x;
      3'd4:    w = d.y;
      default: w = d.z;
    endcase
    return idx[0] ? w[15:8] : w[7:0];
  endfunction

endpackage

// File: rtl/imu_resp_regs.sv
// Register file of the IMU SPI responder: control registers, read mux, output bytes,
// pending-sample buffer and STATUS (GDA/XLDA) flags.
// Ports:
//   addr_i / wr_req_i / wr_data_i : frame address and write request (committed if writable)
//   rd_data_o                     : read mux output for addr_i
//   status_clr_i                  : completed read of STATUS, clears GDA/XLDA
//   cs_high_i / cs_rise_i         : synchronized chip-select level and rising edge
//   sample_i / sample_valid_i     : parallel sample input
//   ctrl*_o                       : control register contents
//   autoinc_en_o                  : address auto-increment enable (CTRL3_C bit 2)
//   wr_strobe_o                   : one-cycle pulse per committed write
// Optional build macro: IMU_RESP_AUTOINC_EN.
module imu_resp_regs
  import imu_pkg::*;
#(
  parameter logic [7:0] WHO_AM_I_VAL = 8'h69
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [6:0] addr_i,
  input  logic       wr_req_i,
  input  logic [7:0] wr_data_i,
  output logic [7:0] rd_data_o,
  input  logic       status_clr_i,
  input  logic       cs_high_i,
  input  logic       cs_rise_i,
  input  data_t      sample_i,
  input  logic       sample_valid_i,
  output logic [7:0] ctrl1_xl_o,
  output logic [7:0] ctrl2_g_o,
  output logic [7:0] ctrl4_c_o,
  output logic [7:0] ctrl9_xl_o,
  output logic       autoinc_en_o,
  output logic       wr_strobe_o
);

  logic [7:0] ctrl1_q, ctrl2_q, ctrl3_q, ctrl4_q, ctrl9_q;
  logic [7:0] ctrl1_d, ctrl2_d, ctrl3_d, ctrl4_d, ctrl9_d;
  data_t      out_q, out_d, pend_q, pend_d;
  logic       pend_vld_q, pend_vld_d;
  logic       gda_q, gda_d, xlda_q, xlda_d;
  logic       wr_strobe_q, wr_strobe_d;

  logic       load_direct, load_pend;
  logic [3:0] out_idx;

  // Samples are deferred while CS is low so a frame never sees a torn multi-byte value.
  assign load_direct = sample_valid_i & cs_high_i;
  assign load_pend   = cs_rise_i & pend_vld_q & ~load_direct;
  assign out_idx     = addr_i[3:0] - 4'd2;

  always_comb begin
    ctrl1_d     = ctrl1_q;
    ctrl2_d     = ctrl2_q;
    ctrl3_d     = ctrl3_q;
    ctrl4_d     = ctrl4_q;
    ctrl9_d     = ctrl9_q;
    wr_strobe_d = 1'b0;
    if (wr_req_i) begin
      wr_strobe_d = 1'b1;
      case (addr_i)
        ADDR_CTRL1_XL: ctrl1_d = wr_data_i;
        ADDR_CTRL2_G:  ctrl2_d = wr_data_i;
        ADDR_CTRL3_C:  ctrl3_d = wr_data_i;
        ADDR_CTRL4_C:  ctrl4_d = wr_data_i;
        ADDR_CTRL9_XL: ctrl9_d = wr_data_i;
        default:       wr_strobe_d = 1'b0;
      endcase
    end
  end

  always_comb begin
    out_d      = out_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    gda_d      = gda_q;
    xlda_d     = xlda_q;
    if (sample_valid_i && !cs_high_i) begin
      pend_d     = sample_i;
      pend_vld_d = 1'b1;
    end else if (load_direct || load_pend) begin
      pend_vld_d = 1'b0;
    end
    if (load_direct) begin
      out_d = sample_i;
    end else if (load_pend) begin
      out_d = pend_q;
    end
    // A load in the same cycle as a STATUS clear keeps the flags set.
    if (load_direct || load_pend) begin
      gda_d  = 1'b1;
      xlda_d = 1'b1;
    end else if (status_clr_i) begin
      gda_d  = 1'b0;
      xlda_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ctrl1_q     <= 8'h00;
      ctrl2_q     <= 8'h00;
      ctrl3_q     <= CTRL3_C_RST;
      ctrl4_q     <= 8'h00;
      ctrl9_q     <= CTRL9_XL_RST;
      out_q       <= '0;
      pend_q      <= '0;
      pend_vld_q  <= 1'b0;
      gda_q       <= 1'b0;
      xlda_q      <= 1'b0;
      wr_strobe_q <= 1'b0;
    end else begin
      ctrl1_q     <= ctrl1_d;
      ctrl2_q     <= ctrl2_d;
      ctrl3_q     <= ctrl3_d;
      ctrl4_q     <= ctrl4_d;
      ctrl9_q     <= ctrl9_d;
      out_q       <= out_d;
      pend_q      <= pend_d;
      pend_vld_q  <= pend_vld_d;
      gda_q       <= gda_d;
      xlda_q      <= xlda_d;
      wr_strobe_q <= wr_strobe_d;
    end
  end

  always_comb begin
    rd_data_o = 8'h00;
    if (addr_i >= ADDR_OUTX_L_G && addr_i <= ADDR_OUTZ_H_XL) begin
      rd_data_o = out_byte(out_q, out_idx);
    end else begin
      case (addr_i)
        ADDR_WHO_AM_I: rd_data_o = WHO_AM_I_VAL;
        ADDR_CTRL1_XL: rd_data_o = ctrl1_q;
        ADDR_CTRL2_G:  rd_data_o = ctrl2_q;
        ADDR_CTRL3_C:  rd_data_o = ctrl3_q;
        ADDR_CTRL4_C:  rd_data_o = ctrl4_q;
        ADDR_CTRL9_XL: rd_data_o = ctrl9_q;
        ADDR_STATUS:   rd_data_o = {6'b0, gda_q, xlda_q};
        default:       rd_data_o = 8'h00;
      endcase
    end
  end

  assign ctrl1_xl_o  = ctrl1_q;
  assign ctrl2_g_o   = ctrl2_q;
  assign ctrl4_c_o   = ctrl4_q;
  assign ctrl9_xl_o  = ctrl9_q;
  assign wr_strobe_o = wr_strobe_q;
`ifdef IMU_RESP_AUTOINC_EN
  assign autoinc_en_o = ctrl3_q[2];
`else
  assign autoinc_en_o = 1'b0;
`endif

endmodule

// File: rtl/imu_spi_responder.sv
// SPI responder emulating a 6-axis IMU (mode 3, MSB first, 16-bit frame: RW, addr[6:0], data).
// Ports:
//   clk_i, rst_ni (async active-low)   : system clock (>= 8x SPC) and reset
//   spc_i, cs_i, sdi_i / sdo_o         : SPI pins (asynchronous to clk_i)
//   sample_i, sample_valid_i           : parallel sample load
//   ctrl1_xl_o, ctrl2_g_o, ctrl4_c_o, ctrl9_xl_o : control registers
//   wr_strobe_o                        : pulse per committed write
//   frame_error_o                      : pulse when CS rises before a frame completes
// Optional build macro: IMU_RESP_AUTOINC_EN (streaming with address auto-increment).
module imu_spi_responder
  import imu_pkg::*;
#(
  parameter logic [7:0]  WHO_AM_I_VAL = 8'h69,
  parameter int unsigned SYNC_STAGES  = 2  // minimum 2
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       spc_i,
  input  logic       cs_i,
  input  logic       sdi_i,
  output logic       sdo_o,
  input  data_t      sample_i,
  input  logic       sample_valid_i,
  output logic [7:0] ctrl1_xl_o,
  output logic [7:0] ctrl2_g_o,
  output logic [7:0] ctrl4_c_o,
  output logic [7:0] ctrl9_xl_o,
  output logic       wr_strobe_o,
  output logic       frame_error_o
);

  logic [SYNC_STAGES-1:0] spc_sync_q, cs_sync_q, sdi_sync_q;
  logic spc_prev_q, cs_prev_q;
  logic spc_s, cs_s, sdi_s;
  logic spc_rise, spc_fall, cs_rise;

  resp_state_e state_q, state_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [6:0]  shift_q, shift_d;
  logic        rw_q, rw_d;
  logic [6:0]  addr_q, addr_d;
  logic        load_tx_q, load_tx_d;
  logic        streamed_q, streamed_d;
  logic        frame_err_q, frame_err_d;
  logic [7:0]  tx_q;
  logic        sdo_q;

  logic        wr_req, status_clr, autoinc_en;
  logic [7:0]  rd_data, wr_data;

  assign spc_s    = spc_sync_q[SYNC_STAGES-1];
  assign cs_s     = cs_sync_q[SYNC_STAGES-1];
  assign sdi_s    = sdi_sync_q[SYNC_STAGES-1];
  assign spc_rise = spc_s & ~spc_prev_q;
  assign spc_fall = ~spc_s & spc_prev_q;
  assign cs_rise  = cs_s & ~cs_prev_q;
  assign wr_data  = {shift_q, sdi_s};

  // CS synchronizer resets low so a CS held low across reset is never mistaken for a new frame.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      spc_sync_q <= '1;
      cs_sync_q  <= '0;
      sdi_sync_q <= '0;
      spc_prev_q <= 1'b1;
      cs_prev_q  <= 1'b0;
    end else begin
      spc_sync_q <= {spc_sync_q[SYNC_STAGES-2:0], spc_i};
      cs_sync_q  <= {cs_sync_q[SYNC_STAGES-2:0], cs_i};
      sdi_sync_q <= {sdi_sync_q[SYNC_STAGES-2:0], sdi_i};
      spc_prev_q <= spc_s;
      cs_prev_q  <= cs_s;
    end
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    rw_d        = rw_q;
    addr_d      = addr_q;
    load_tx_d   = 1'b0;
    streamed_d  = streamed_q;
    frame_err_d = 1'b0;
    wr_req      = 1'b0;
    status_clr  = 1'b0;
    unique case (state_q)
      StWaitCs: if (cs_s) state_d = StIdle;
      StIdle: begin
        if (!cs_s) begin
          state_d    = StAddr;
          bit_cnt_d  = 4'd0;
          streamed_d = 1'b0;
        end
      end
      StAddr: begin
        if (cs_s) begin
          state_d     = StIdle;
          frame_err_d = 1'b1;
        end else if (spc_rise) begin
          shift_d   = {shift_q[5:0], sdi_s};
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd7) begin
            rw_d      = shift_q[6];
            addr_d    = {shift_q[5:0], sdi_s};
            load_tx_d = 1'b1;
            state_d   = StData;
          end
        end
      end
      StData: begin
        if (cs_s) begin
          // Ending a stream after at least one whole data byte is a clean stop.
          state_d     = StIdle;
          frame_err_d = ~streamed_q;
        end else if (spc_rise) begin
          shift_d   = {shift_q[5:0], sdi_s};
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd15) begin
            wr_req     = ~rw_q;
            status_clr = rw_q && (addr_q == ADDR_STATUS);
            if (autoinc_en) begin
              bit_cnt_d  = 4'd8;
              addr_d     = addr_q + 7'd1;
              load_tx_d  = 1'b1;
              streamed_d = 1'b1;
            end else begin
              state_d = StWaitCs;
            end
          end
        end
      end
      default: state_d = StWaitCs;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StWaitCs;
      bit_cnt_q   <= 4'd0;
      shift_q     <= '0;
      rw_q        <= 1'b0;
      addr_q      <= '0;
      load_tx_q   <= 1'b0;
      streamed_q  <= 1'b0;
      frame_err_q <= 1'b0;
      tx_q        <= '0;
      sdo_q       <= 1'b1;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      rw_q        <= rw_d;
      addr_q      <= addr_d;
      load_tx_q   <= load_tx_d;
      streamed_q  <= streamed_d;
      frame_err_q <= frame_err_d;
      // The byte is captured one cycle after the address settles; the first SPC fall of the
      // data phase comes several clocks later.
      if (load_tx_q) begin
        tx_q <= rd_data;
      end else if (state_q == StData && rw_q && spc_fall) begin
        tx_q <= {tx_q[6:0], 1'b0};
      end
      if (state_q == StData && rw_q) begin
        if (spc_fall) sdo_q <= tx_q[7];
      end else begin
        sdo_q <= 1'b1;
      end
    end
  end

  assign sdo_o         = sdo_q;
  assign frame_error_o = frame_err_q;

  imu_resp_regs #(
    .WHO_AM_I_VAL (WHO_AM_I_VAL)
  ) u_regs (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .addr_i         (addr_q),
    .wr_req_i       (wr_req),
    .wr_data_i      (wr_data),
    .rd_data_o      (rd_data),
    .status_clr_i   (status_clr),
    .cs_high_i      (cs_s),
    .cs_rise_i      (cs_rise),
    .sample_i       (sample_i),
    .sample_valid_i (sample_valid_i),
    .ctrl1_xl_o     (ctrl1_xl_o),
    .ctrl2_g_o      (ctrl2_g_o),
    .ctrl4_c_o      (ctrl4_c_o),
    .ctrl9_xl_o     (ctrl9_xl_o),
    .autoinc_en_o   (autoinc_en),
    .wr_strobe_o    (wr_strobe_o)
  );

endmodule

// File: tb/tb_imu_spi_responder.sv
// Self-checking bench for imu_spi_responder: SPI mode-3 initiator tasks plus a register-level
// reference model (register bytes, output bytes, STATUS flags) updated from the register map.
module tb_imu_spi_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        spc = 1'b1;
  logic        cs = 1'b1;
  logic        sdi = 1'b0;
  logic        sdo;
  logic [95:0] sample = '0;
  logic        sample_valid = 1'b0;
  logic [7:0]  ctrl1_xl, ctrl2_g, ctrl4_c, ctrl9_xl;
  logic        wr_strobe, frame_error;

  int total = 0;
  int bad = 0;
  int wr_cnt = 0;
  int fe_cnt = 0;

  always #5 clk = ~clk;

  imu_spi_responder dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .spc_i          (spc),
    .cs_i           (cs),
    .sdi_i          (sdi),
    .sdo_o          (sdo),
    .sample_i       (sample),
    .sample_valid_i (sample_valid),
    .ctrl1_xl_o     (ctrl1_xl),
    .ctrl2_g_o      (ctrl2_g),
    .ctrl4_c_o      (ctrl4_c),
    .ctrl9_xl_o     (ctrl9_xl),
    .wr_strobe_o    (wr_strobe),
    .frame_error_o  (frame_error)
  );

  always @(negedge clk) begin
    if (wr_strobe === 1'b1) wr_cnt++;
    if (frame_error === 1'b1) fe_cnt++;
  end

  // ---------------- reference model ----------------
  logic [7:0] m_c1, m_c2, m_c3, m_c4, m_c9, m_status;
  logic [7:0] m_out [12];

  task automatic model_reset();
    m_c1 = 8'h00; m_c2 = 8'h00; m_c4 = 8'h00; m_c9 = 8'hE0; m_status = 8'h00;
`ifdef IMU_RESP_AUTOINC_EN
    m_c3 = 8'h04;
`else
    m_c3 = 8'h00;
`endif
    for (int i = 0; i < 12; i++) m_out[i] = 8'h00;
  endtask

  // Sample word k (0 = pitch ... 5 = z) sits at bits 95-16k; register space is little-endian.
  task automatic model_load(input logic [95:0] s);
    logic [15:0] w;
    for (int k = 0; k < 6; k++) begin
      w = s[95-16*k -: 16];
      m_out[2*k]   = w[7:0];
      m_out[2*k+1] = w[15:8];
    end
    m_status = 8'h03;
  endtask

  function automatic logic [7:0] model_read(input logic [6:0] a);
    if (a >= 7'h22 && a <= 7'h2D) return m_out[int'(a) - 'h22];
    case (a)
      7'h0F:   return 8'h69;
      7'h10:   return m_c1;
      7'h11:   return m_c2;
      7'h12:   return m_c3;
      7'h13:   return m_c4;
      7'h18:   return m_c9;
      7'h1E:   return m_status;
      default: return 8'h00;
    endcase
  endfunction

  // Returns 1 when the write is expected to commit.
  function automatic bit model_write(input logic [6:0] a, input logic [7:0] d);
    case (a)
      7'h10: m_c1 = d;
      7'h11: m_c2 = d;
      7'h12: m_c3 = d;
      7'h13: m_c4 = d;
      7'h18: m_c9 = d;
      default: return 1'b0;
    endcase
    return 1'b1;
  endfunction

  // ---------------- initiator tasks ----------------
  task automatic spi_xfer(input int nbits, input logic [103:0] mosi, output logic [103:0] miso);
    miso = '0;
    cs = 1'b0;
    #100;
    for (int i = 0; i < nbits; i++) begin
      spc = 1'b0;
      sdi = mosi[nbits-1-i];
      #50;
      miso[nbits-1-i] = sdo;
      spc = 1'b1;
      #50;
    end
    #50;
    cs = 1'b1;
    #200;
  endtask

  task automatic spi_read(input logic [6:0] a, output logic [7:0] d);
    logic [103:0] m;
    spi_xfer(16, {88'b0, 1'b1, a, 8'h00}, m);
    d = m[7:0];
  endtask

  task automatic spi_write(input logic [6:0] a, input logic [7:0] d);
    logic [103:0] m;
    spi_xfer(16, {88'b0, 1'b0, a, d}, m);
  endtask

  task automatic pulse_sample(input logic [95:0] s);
    @(negedge clk);
    sample = s;
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  function automatic logic [95:0] rand_sample();
    return {$urandom, $urandom, $urandom};
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [7:0] d;
    rst_n = 1'b0;
    model_reset();
    #50;
    rst_n = 1'b1;
    #100;
    total++; if (sdo !== 1'b1) begin bad++; $display("FAIL reset_sdo got=%b exp=1", sdo); end
    total++; if (ctrl1_xl !== 8'h00) begin bad++; $display("FAIL reset_ctrl1 got=%h exp=00", ctrl1_xl); end
    total++; if (ctrl2_g !== 8'h00) begin bad++; $display("FAIL reset_ctrl2 got=%h exp=00", ctrl2_g); end
    total++; if (ctrl4_c !== 8'h00) begin bad++; $display("FAIL reset_ctrl4 got=%h exp=00", ctrl4_c); end
    total++; if (ctrl9_xl !== 8'hE0) begin bad++; $display("FAIL reset_ctrl9 got=%h exp=e0", ctrl9_xl); end
    total++; if (wr_strobe !== 1'b0 || frame_error !== 1'b0) begin
      bad++; $display("FAIL reset_pulses got=%b%b exp=00", wr_strobe, frame_error);
    end
    spi_read(7'h1E, d);
    total++; if (d !== 8'h00) begin bad++; $display("FAIL reset_status got=%h exp=00", d); end
    spi_read(7'h12, d);
    total++; if (d !== model_read(7'h12)) begin
      bad++; $display("FAIL reset_ctrl3 got=%h exp=%h", d, model_read(7'h12));
    end
  endtask

  task automatic test_whoami();
    logic [7:0] d;
    int fe0 = fe_cnt;
    spi_read(7'h0F, d);
    total++; if (d !== 8'h69) begin bad++; $display("FAIL whoami got=%h exp=69", d); end
    total++; if (fe_cnt !== fe0) begin bad++; $display("FAIL whoami_fe got=%0d exp=%0d", fe_cnt, fe0); end
  endtask

  task automatic test_write();
    logic [7:0] d;
    int wr0 = wr_cnt;
    void'(model_write(7'h10, 8'h50));
    spi_write(7'h10, 8'h50);
    total++; if (wr_cnt !== wr0 + 1) begin bad++; $display("FAIL wr_strobe got=%0d exp=%0d", wr_cnt, wr0 + 1); end
    total++; if (ctrl1_xl !== 8'h50) begin bad++; $display("FAIL wr_ctrl1 got=%h exp=50", ctrl1_xl); end
    wr0 = wr_cnt;
    spi_write(7'h22, 8'hA5);
    total++; if (wr_cnt !== wr0) begin bad++; $display("FAIL wr_ro_strobe got=%0d exp=%0d", wr_cnt, wr0); end
    spi_read(7'h22, d);
    total++; if (d !== model_read(7'h22)) begin
      bad++; $display("FAIL wr_ro_read got=%h exp=%h", d, model_read(7'h22));
    end
  endtask

  task automatic test_sample();
    logic [95:0] s;
    logic [7:0] d;
    logic [6:0] a;
    s = rand_sample();
    s[95:80] = 16'h1234;
    s[15:0]  = 16'hABCD;
    pulse_sample(s);
    model_load(s);
    #20;
    for (int i = 0; i < 12; i++) begin
      a = 7'h22 + 7'(i);
      spi_read(a, d);
      total++; if (d !== model_read(a)) begin
        bad++; $display("FAIL sample_byte addr=%h got=%h exp=%h", a, d, model_read(a));
      end
    end
    spi_read(7'h1E, d);
    total++; if (d !== 8'h03) begin bad++; $display("FAIL status_set got=%h exp=03", d); end
    m_status = 8'h00;
    spi_read(7'h1E, d);
    total++; if (d !== 8'h00) begin bad++; $display("FAIL status_clr got=%h exp=00", d); end
  endtask

  task automatic test_sample_during_read();
    logic [95:0] s;
    logic [7:0] d_old, d;
    logic [7:0] exp_old;
    s = rand_sample();
    s[95:88] = ~m_out[1];  // make sure the high pitch byte changes
    exp_old = model_read(7'h23);
    fork
      spi_read(7'h23, d_old);
      begin #400; pulse_sample(s); end
    join
    total++; if (d_old !== exp_old) begin bad++; $display("FAIL torn_old got=%h exp=%h", d_old, exp_old); end
    model_load(s);
    spi_read(7'h23, d);
    total++; if (d !== model_read(7'h23)) begin
      bad++; $display("FAIL torn_new got=%h exp=%h", d, model_read(7'h23));
    end
    spi_read(7'h1E, d);
    m_status = 8'h00;
    total++; if (d !== 8'h03) begin bad++; $display("FAIL torn_status got=%h exp=03", d); end
  endtask

  task automatic test_abort();
    logic [103:0] m;
    logic [7:0] v;
    int fe0 = fe_cnt;
    int wr0 = wr_cnt;
    spi_xfer(10, {94'b0, 1'b0, 7'h11, 2'b11}, m);
    total++; if (fe_cnt !== fe0 + 1) begin bad++; $display("FAIL abort_fe got=%0d exp=%0d", fe_cnt, fe0 + 1); end
    total++; if (wr_cnt !== wr0) begin bad++; $display("FAIL abort_wr got=%0d exp=%0d", wr_cnt, wr0); end
    total++; if (ctrl2_g !== m_c2) begin bad++; $display("FAIL abort_ctrl2 got=%h exp=%h", ctrl2_g, m_c2); end
    v = 8'($urandom) | 8'h01;
    void'(model_write(7'h11, v));
    spi_write(7'h11, v);
    total++; if (ctrl2_g !== m_c2) begin bad++; $display("FAIL after_abort_ctrl2 got=%h exp=%h", ctrl2_g, m_c2); end
    total++; if (wr_cnt !== wr0 + 1 || fe_cnt !== fe0 + 1) begin
      bad++; $display("FAIL after_abort_pulses wr=%0d fe=%0d exp wr=%0d fe=%0d",
                      wr_cnt, fe_cnt, wr0 + 1, fe0 + 1);
    end
  endtask

  task automatic test_random();
    logic [6:0] wr_addrs [7];
    logic [6:0] a;
    logic [7:0] d, e;
    logic [95:0] s;
    int wr0;
    bit commit;
    wr_addrs = '{7'h10, 7'h11, 7'h12, 7'h13, 7'h18, 7'h0F, 7'h1E};
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 3))
        0: begin
          a = 7'($urandom_range(0, 127));
          e = model_read(a);
          spi_read(a, d);
          if (a == 7'h1E) m_status = 8'h00;
          total++; if (d !== e) begin bad++; $display("FAIL rnd_read addr=%h got=%h exp=%h", a, d, e); end
        end
        1: begin
          a = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : wr_addrs[$urandom_range(0, 6)];
          d = 8'($urandom);
          wr0 = wr_cnt;
          commit = model_write(a, d);
          spi_write(a, d);
          total++; if (wr_cnt !== wr0 + int'(commit)) begin
            bad++; $display("FAIL rnd_wr_strobe addr=%h got=%0d exp=%0d", a, wr_cnt - wr0, commit);
          end
          total++; if ({ctrl1_xl, ctrl2_g, ctrl4_c, ctrl9_xl} !== {m_c1, m_c2, m_c4, m_c9}) begin
            bad++; $display("FAIL rnd_ctrl got=%h%h%h%h exp=%h%h%h%h", ctrl1_xl, ctrl2_g, ctrl4_c,
                            ctrl9_xl, m_c1, m_c2, m_c4, m_c9);
          end
        end
        2: begin
          s = rand_sample();
          pulse_sample(s);
          model_load(s);
          #20;
        end
        default: begin
          a = 7'h22 + 7'($urandom_range(0, 11));
          e = model_read(a);
          spi_read(a, d);
          total++; if (d !== e) begin bad++; $display("FAIL rnd_out addr=%h got=%h exp=%h", a, d, e); end
        end
      endcase
    end
  endtask

  task automatic test_reset_midframe();
    logic [103:0] m;
    logic [7:0] d;
    int wr0;
    cs = 1'b0;
    #100;
    for (int i = 0; i < 5; i++) begin
      spc = 1'b0; sdi = 1'b1; #50; spc = 1'b1; #50;
    end
    rst_n = 1'b0;
    model_reset();
    #30;
    total++; if ({sdo, wr_strobe, frame_error} !== 3'b100) begin
      bad++; $display("FAIL midrst_pins got=%b exp=100", {sdo, wr_strobe, frame_error});
    end
    total++; if ({ctrl1_xl, ctrl2_g, ctrl4_c, ctrl9_xl} !== 32'h000000E0) begin
      bad++; $display("FAIL midrst_ctrl got=%h%h%h%h exp=000000e0", ctrl1_xl, ctrl2_g, ctrl4_c, ctrl9_xl);
    end
    rst_n = 1'b1;
    #100;
    // CS still low from before the reset: this frame must be ignored.
    wr0 = wr_cnt;
    for (int i = 0; i < 16; i++) begin
      spc = 1'b0;
      sdi = (i == 3 || i >= 8) ? 1'b1 : 1'b0;  // write 0x10 <- 0xFF
      #50;
      m[i] = sdo;
      spc = 1'b1;
      #50;
    end
    total++; if (m[15:0] !== 16'hFFFF) begin bad++; $display("FAIL midrst_sdo got=%h exp=ffff", m[15:0]); end
    total++; if (wr_cnt !== wr0 || ctrl1_xl !== 8'h00) begin
      bad++; $display("FAIL midrst_nowrite wr=%0d ctrl1=%h exp wr=%0d ctrl1=00", wr_cnt, ctrl1_xl, wr0);
    end
    #50;
    cs = 1'b1;
    #200;
    spi_read(7'h0F, d);
    total++; if (d !== 8'h69) begin bad++; $display("FAIL midrst_recover got=%h exp=69", d); end
  endtask

`ifdef IMU_RESP_AUTOINC_EN
  task automatic test_autoinc();
    logic [103:0] m;
    logic [95:0] s;
    int fe0;
    void'(model_write(7'h12, 8'h04));
    spi_write(7'h12, 8'h04);
    s = rand_sample();
    pulse_sample(s);
    model_load(s);
    #20;
    fe0 = fe_cnt;
    spi_xfer(104, {1'b1, 7'h22, 96'b0}, m);
    for (int k = 0; k < 12; k++) begin
      total++; if (m[95-8*k -: 8] !== m_out[k]) begin
        bad++; $display("FAIL autoinc_byte k=%0d got=%h exp=%h", k, m[95-8*k -: 8], m_out[k]);
      end
    end
    total++; if (fe_cnt !== fe0) begin bad++; $display("FAIL autoinc_fe got=%0d exp=%0d", fe_cnt, fe0); end
  endtask
`endif

  initial begin
    #2;
    test_reset();
    test_whoami();
    test_write();
    test_sample();
    test_sample_during_read();
    test_abort();
    test_random();
    test_reset_midframe();
`ifdef IMU_RESP_AUTOINC_EN
    test_autoinc();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #900us;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/imu_spi_responder.md
Name: imu_spi_responder

Overview:
- SPI responder model of the 6-axis IMU: answers the register reads and writes issued by the IMU SPI initiator.
- Used as the far-end device in system simulation, and on a second board as an IMU emulator.
- Holds the control registers, WHO_AM_I, STATUS and the 12 output bytes; the output bytes are loaded from a parallel sample port.
- SPI mode 3 (SPC idle high), MSB first, 16-bit frame: RW bit (1 = read), 7-bit address, 8 data bits.

Parameters:
- WHO_AM_I_VAL, 8'h69, value returned at address 0x0F.
- SYNC_STAGES, 2, synchronizer depth on SPC/CS/SDI; minimum 2.

Ports:
- clk  in  1  system clock; must be at least 8x SPC frequency.
- reset  in  1  asynchronous, active-low reset.
- SPC  in  1  serial clock from initiator.
- CS  in  1  chip select, active low.
- SDI  in  1  serial data from initiator.
- SDO  out  1  serial data to initiator.
- sample_in  in  96  data_t {pitch, roll, yaw, x, y, z}, each 16-bit little-endian in register space.
- sample_valid  in  1  one-cycle strobe: new sample available.
- ctrl1_xl, ctrl2_g, ctrl4_c, ctrl9_xl  out  8 each  current control register contents.
- wr_strobe  out  1  one-cycle pulse on a committed write.
- frame_error  out  1  one-cycle pulse when a frame is aborted.

Behaviour:
- Reset values (reset low): SDO=1; all ctrl regs 8'h00 except ctrl9_xl=8'hE0; output bytes 0; STATUS 0; pulses 0; FSM=WAIT_CS.
- Input sync: SPC, CS and SDI each pass through SYNC_STAGES flops; rise and fall of the synced SPC are edge-detected.
- FSM states and transitions:
  - WAIT_CS: CS high -> IDLE.
  - IDLE: CS falling -> ADDR, bit counter=0.
  - ADDR: shift SDI on each SPC rise; after rise 8, latch rw/addr[6:0] -> DATA.
  - DATA: read: on each SPC fall, drive the next bit of the addressed byte, MSB first, starting at the fall after rise 8. Write: shift SDI on each rise. After rise 16 -> WAIT_CS.
- Write commit: on rise 16, only if addr is 0x10, 0x11, 0x12, 0x13 or 0x18. Updates the register and pulses wr_strobe the next cycle. Writes to any other address are silently dropped, with no wr_strobe.
- Read map:
  - 0x0F -> WHO_AM_I_VAL.
  - 0x10-0x13, 0x18 -> control registers.
  - 0x1E -> STATUS {6'b0, GDA, XLDA}.
  - 0x22-0x2D -> output bytes (0x22 = pitch[7:0] … 0x2D = z[15:8]).
  - Any other address -> 8'h00.
- SDO latency: updated no later than 3 clk cycles after the SPC fall at the pins. SDO=1 whenever the FSM is not in a read DATA phase.
- Sample load:
  - sample_valid with CS high: copy to output bytes the next cycle; set GDA and XLDA.
  - sample_valid while CS low: hold in a pending buffer. Apply on the cycle after CS rises, so no torn multi-byte reads within a frame.
  - A newer pending sample overwrites an older one.
- STATUS clear: a completed read of 0x1E clears GDA and XLDA at end of frame. If a load lands in the same cycle, the load wins and the bits stay set.
- Abort: CS rises before rise 16 -> no write, frame_error pulse, go to IDLE.
- Extra SPC edges in WAIT_CS are ignored, unless IMU_RESP_AUTOINC_EN is defined.
- Reset mid-frame: state cleared; FSM waits for CS high before accepting a frame.
- ctrl outputs are registered and change only on committed writes.

Optional Feature:
- Macro: IMU_RESP_AUTOINC_EN.
- Defined: when CTRL3_C (0x12) bit 2 is set (reset value 1 in this build), continued SPC clocking past bit 16 with CS low streams further bytes. Address increments per byte: read returns successive bytes; write commits each full byte with its own wr_strobe. Address wraps 0x7F -> 0x00.
- Not defined: frame is fixed at 16 bits. CTRL3_C bit 2 resets to 0 and has no effect.

Decomposition:
- imu_pkg holds:
  - data_t;
  - register address constants (ADDR_CTRL1_XL, ADDR_OUTX_L_G, ADDR_STATUS, …);
  - CTRL9_XL reset value;
  - responder FSM state enum.
- Sub-module imu_resp_regs: register file, read mux, pending-sample buffer and STATUS logic. The top level keeps the sync/edge detection, shift register and FSM.

Test Plan:
- Read 0x0F (SDI 8'h8F, then 8 dummy bits) -> SDO shifts 8'h69; frame_error=0.
- Write 0x10 data 8'h50 -> one wr_strobe; ctrl1_xl=8'h50. Write to 0x22 -> no wr_strobe, and a later read of 0x22 returns the sample byte.
- Load sample pitch=16'h1234, z=16'hABCD -> reads of 0x22/0x23/0x2C/0x2D return 34/12/CD/AB. Read 0x1E returns 8'h03, then the next read returns 8'h00.
- sample_valid during a read of 0x23 -> the frame returns the old byte; the next frame returns the new byte.
- CS raised after 10 SPC rises of a write to 0x11 -> frame_error pulse; ctrl2_g unchanged; the next full frame works.
- Reset asserted mid-frame with CS held low -> outputs at reset values; no response until CS goes high and then low again. With IMU_RESP_AUTOINC_EN, a 104-bit read from 0x22 returns all 12 bytes in order.
